uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin, packet-locked arbiter that shares one `uart_tx` serializer among `N_REQ` byte-stream requesters, such as the AT-command sender and the debug/status reporter in the ESP Wi-Fi path. It sits directly in front of `uart_tx`. It grants the serializer to one requester for a whole packet, delimited by `req_last`. For each byte it pulses `tx_req`, then waits for the frame to start and finish, using the serializer's idle flag. It also recovers from stalled requesters and from a serializer that never starts.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `START_TO`, 8: cycles allowed after `tx_req` for `tx_idle` to fall before abort.
- `HOLD_TO`, 65535: cycles a granted requester may leave `req_vld` low mid-packet before the grant is revoked.

Ports:
- `clk` in 1: system clock (`SYS_FRQ`).
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_vld` in N_REQ: per-requester byte valid.
- `req_data` in N_REQ*8: requester i byte on [8i+7:8i].
- `req_last` in N_REQ: marks the final byte of a packet.
- `req_rdy` out N_REQ: one-hot accept strobe, combinational.
- `tx_req` out 1: registered one-cycle pulse to `uart_tx`.
- `tx_din` out 8: registered byte to `uart_tx`, held until the next load.
- `tx_idle` in 1: `uart_tx.dout_vld`; high = serializer idle.
- `grant` out N_REQ: registered one-hot current owner; all-zero when idle.
- `busy` out 1: registered; high whenever state is not IDLE.
- `err` out 1: registered one-cycle pulse on either timeout.

## Operation
- **Reset values:** state IDLE; `grant`=0; rr pointer `ptr`=0; `tx_req`=0; `tx_din`=8'h00; `busy`=0; `err`=0; timers=0.
- **IDLE:**
  - If any `req_vld`, pick the first asserted index searching from `ptr` upward, with wrap.
  - Register `grant`, set `busy`, go to LOAD.
  - `req_vld` seen in IDLE is not consumed.
- **LOAD:**
  - `req_rdy[g]` = `req_vld[g]` for the granted index g; all other `req_rdy` bits are 0.
  - On accept: `tx_din`<=byte, `tx_req`<=1 for the next cycle only, `last_q`<=`req_last[g]`, clear timer, go to WAIT_START.
  - Otherwise increment the hold timer. When it reaches `HOLD_TO`: pulse `err`, set `ptr`=g+1 mod N_REQ, clear `grant`, go to IDLE.
- **WAIT_START:**
  - Ignore `tx_idle` on the first cycle, when `tx_req` is still high, because `uart_tx` raises its busy flag one cycle after `tx_req`.
  - On `tx_idle`==0, go to WAIT_DONE.
  - If `START_TO` cycles pass with no fall: pulse `err`, release the grant as above, go to IDLE.
- **WAIT_DONE:**
  - On `tx_idle`==1, go to LOAD if `last_q`==0.
  - If `last_q`==1: `ptr`=g+1 mod N_REQ, `grant`<=0, go to IDLE.
- **Fairness:** the grant is never preempted mid-packet. A requester that just finished has the lowest priority in the next arbitration.
- **Masking:** `req_vld` of non-granted requesters is ignored while `busy`.
- **Reset mid-frame:** all outputs return to their reset values immediately. The partially sent byte is abandoned; `uart_tx` shares `rst_n`.

## Timing
- IDLE with `req_vld` at cycle t: `grant` at t+1, `req_rdy[g]` during LOAD at t+1.
- Accept at t+1: `tx_req`=1 at t+2, `tx_idle` falls by t+3.
- Per-byte period = 10·(`SYS_FRQ`/`BAUD_MAX`) + 3 cycles, for the LOAD, `tx_req` and ignore cycles.
- After the final byte, `tx_idle` rises at u: `grant`=0 and IDLE at u+1. Earliest next grant is u+2.
- Zero-gap back-to-back bytes are not required.
- Simultaneous `req_vld` on all inputs with `ptr`=2: grant goes to index 2.

## Structure
- Rate macros `SYS_FRQ` and `BAUD_MAX` stay in the shared `param.v`.
- Add `` `ARB_N_REQ `` to `param.v` so the top level and the bench agree on the requester count.
- State encoding (IDLE, LOAD, WAIT_START, WAIT_DONE) is localparam, internal to the module.
- One sub-module: `rr_pick`, a combinational round-robin picker. Inputs: `req[N-1:0]`, `ptr`. Outputs: one-hot `gnt` and binary index.

## Test plan
- **Single packet:** requester 0 sends 8'h41, 8'h54 with `last` on the second byte → `uart_tx` line shows 0x41 then 0x54 (LSB first, start/stop bits). `grant` returns to 0 and `ptr`=1.
- **Contention:** all four requesters assert from reset, each with 2 bytes → packets complete in order 0,1,2,3. Each packet's bytes are contiguous with no interleaving.
- **Fairness:** requester 1 re-requests immediately after finishing while requester 3 is waiting → 3 is granted before 1.
- **Hold timeout:** granted requester drops `req_vld` after byte 1 of 3 → `err` pulses at `HOLD_TO`, grant is released, and the next pending requester is served.
- **Start timeout:** `tx_idle` tied high → `err` pulses `START_TO` cycles after `tx_req` and the FSM returns to IDLE.
- **Reset mid-frame:** assert `rst_n`=0 during bit 4 → `tx_req`=0, `grant`=0, `busy`=0 immediately. After release, the next request proceeds normally.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared constants and helpers for the packet-locked UART transmit arbiter.
package uart_tx_arb_pkg;

   localparam int unsigned ARB_N_REQ = 4;
   localparam int unsigned BYTE_W    = 8;

   // Round-robin successor of index g among n requesters.
   function automatic int unsigned next_idx(input int unsigned g, input int unsigned n);
      return (g + 32'd1 >= n) ? 32'd0 : g + 32'd1;
   endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap.
module uart_tx_arb_rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int unsigned N  = ARB_N_REQ,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   always_comb begin
      logic          found;
      logic [IW-1:0] j;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j = IW'((32'(ptr) + i) % N);
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx serializer among N_REQ byte streams, one whole packet per grant,
// with timeouts for stalled requesters and a serializer that never starts.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = ARB_N_REQ,
   parameter int unsigned START_TO = 8,
   parameter int unsigned HOLD_TO  = 65535
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_vld,
   input  logic [N_REQ*BYTE_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_rdy,
   output logic                    tx_req,
   output logic [BYTE_W-1:0]       tx_din,
   input  logic                    tx_idle,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic                    err
);

   localparam int unsigned   IW        = $clog2(N_REQ);
   localparam int unsigned   T_MAX     = (HOLD_TO > START_TO) ? HOLD_TO : START_TO;
   localparam int unsigned   TW        = $clog2(T_MAX + 1);
   localparam logic [TW-1:0] HOLD_LIM  = TW'(HOLD_TO - 1);
   localparam logic [TW-1:0] START_LIM = TW'(START_TO - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

   state_t            state;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     g_idx;
   logic [IW-1:0]     ptr_next;
   logic [TW-1:0]     timer;
   logic              last_q;
   logic [N_REQ-1:0]  pick_gnt;
   logic [IW-1:0]     pick_idx;
   logic [BYTE_W-1:0] req_byte [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_byte
      assign req_byte[i] = req_data[i*BYTE_W +: BYTE_W];
   end

   uart_tx_arb_rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
      .req (req_vld),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // Only the owner can be accepted, and only while a byte is being loaded.
   assign req_rdy  = (state == LOAD) ? (grant & req_vld) : '0;
   assign ptr_next = IW'(next_idx(32'(g_idx), N_REQ));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         grant  <= '0;
         g_idx  <= '0;
         ptr    <= '0;
         timer  <= '0;
         last_q <= 1'b0;
         tx_req <= 1'b0;
         tx_din <= '0;
         busy   <= 1'b0;
         err    <= 1'b0;
      end else begin
         tx_req <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_vld) begin
                  grant <= pick_gnt;
                  g_idx <= pick_idx;
                  busy  <= 1'b1;
                  timer <= '0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (req_vld[g_idx]) begin
                  tx_din <= req_byte[g_idx];
                  tx_req <= 1'b1;
                  last_q <= req_last[g_idx];
                  timer  <= '0;
                  state  <= WAIT_START;
               end else if (timer == HOLD_LIM) begin
                  err   <= 1'b1;
                  ptr   <= ptr_next;
                  grant <= '0;
                  busy  <= 1'b0;
                  timer <= '0;
                  state <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_START: begin
               // uart_tx drops its idle flag one cycle after tx_req, so skip that cycle.
               if (!tx_req && !tx_idle) begin
                  timer <= '0;
                  state <= WAIT_DONE;
               end else if (timer == START_LIM) begin
                  err   <= 1'b1;
                  ptr   <= ptr_next;
                  grant <= '0;
                  busy  <= 1'b0;
                  timer <= '0;
                  state <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_DONE: begin
               if (tx_idle) begin
                  timer <= '0;
                  if (last_q) begin
                     ptr   <= ptr_next;
                     grant <= '0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb with a behavioural uart_tx idle-flag model.
module tb_uart_tx_arb;
   import uart_tx_arb_pkg::*;

   localparam int unsigned N        = ARB_N_REQ;
   localparam int unsigned START_TO = 8;
   localparam int unsigned HOLD_TO  = 20;
   localparam int          FRAME    = 12;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_vld, req_last, req_rdy, grant;
   logic [N*8-1:0] req_data;
   logic           tx_req, tx_idle, busy, err;
   logic [7:0]     tx_din;

   uart_tx_arb #(.N_REQ(N), .START_TO(START_TO), .HOLD_TO(HOLD_TO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_vld  (req_vld),
      .req_data (req_data),
      .req_last (req_last),
      .req_rdy  (req_rdy),
      .tx_req   (tx_req),
      .tx_din   (tx_din),
      .tx_idle  (tx_idle),
      .grant    (grant),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Serializer model: busy for FRAME cycles starting the cycle after tx_req.
   int   ser_cnt = 0;
   logic stuck   = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ser_cnt <= 0;
      else if (ser_cnt != 0)   ser_cnt <= ser_cnt - 1;
      else if (tx_req && !stuck) ser_cnt <= FRAME;
   end
   assign tx_idle = (ser_cnt == 0);

   // Requester model: per-requester byte FIFOs, popped when req_rdy was seen.
   logic [8:0]   mem [N][256];
   int           wp [N];
   int           rp [N];
   logic [N-1:0] en  = '0;
   logic [N-1:0] acc = '0;
   int           flush_cnt = 0, flush_seen = 0;
   always begin
      @(negedge clk);
      if (flush_seen != flush_cnt) begin
         flush_seen = flush_cnt;
         for (int i = 0; i < N; i++) rp[i] = wp[i];
         acc = '0;
      end
      for (int i = 0; i < N; i++) begin
         if (acc[i]) rp[i] = rp[i] + 1;
         req_vld[i]         = en[i] && (rp[i] < wp[i]);
         req_data[i*8 +: 8] = mem[i][rp[i] & 255][7:0];
         req_last[i]        = mem[i][rp[i] & 255][8];
      end
      #1;
      acc = req_rdy;
   end

   function automatic int oh2i(input logic [N-1:0] g);
      int r = -1;
      for (int i = 0; i < N; i++) if (g[i]) r = i;
      return r;
   endfunction

   // Monitor: logs every tx_req with its owner and cycle, plus event timestamps.
   int           cyc = 0, log_n = 0, err_cnt = 0, err_cyc = 0, rise_cyc = 0;
   int           gnt_set_cyc = 0, gnt_clr_cyc = 0, vld_rise_cyc = 0;
   int           log_idx [256];
   int           log_cyc [256];
   logic [7:0]   log_dat [256];
   logic         idle_q  = 1'b1;
   logic [N-1:0] grant_q = '0, vld_q = '0;
   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (tx_req === 1'b1 && log_n < 256) begin
         log_idx[log_n] = oh2i(grant);
         log_dat[log_n] = tx_din;
         log_cyc[log_n] = cyc;
         log_n++;
      end
      if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (tx_idle && !idle_q) rise_cyc = cyc;
      if (grant != '0 && grant_q == '0) gnt_set_cyc = cyc;
      if (grant == '0 && grant_q != '0) gnt_clr_cyc = cyc;
      if (req_vld != '0 && vld_q == '0) vld_rise_cyc = cyc;
      idle_q  = tx_idle;
      grant_q = grant;
      vld_q   = req_vld;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_chk = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_entry(input string name, input int k, input int idx, input logic [7:0] d);
      check(name, 32'(log_idx[k]) * 32'd256 + 32'(log_dat[k]), 32'(idx) * 32'd256 + 32'(d));
   endtask

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      mem[i][wp[i] & 255] = {l, d};
      wp[i] = wp[i] + 1;
   endtask

   function automatic bit q_empty();
      for (int i = 0; i < N; i++) if (rp[i] != wp[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      en    = '0;
      stuck = 1'b0;
      flush_cnt++;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while (!(busy === 1'b0 && q_empty()) && k < budget) begin tick(); k++; end
      check({name, "_done"}, 32'(k < budget), 32'd1);
   endtask

   task automatic wait_log(input string name, input int n, input int budget);
      int k = 0;
      while (log_n < n && k < budget) begin tick(); k++; end
      check({name, "_txreq"}, 32'(k < budget), 32'd1);
   endtask

   task automatic wait_err(input string name, input int base, input int budget);
      int k = 0;
      while (err_cnt <= base && k < budget) begin tick(); k++; end
      check({name, "_err"}, 32'(k < budget), 32'd1);
   endtask

   typedef struct {
      int           warm;  // requester sending a warm-up packet to move ptr, or -1
      logic [N-1:0] vld;
      logic [N-1:0] exp;
   } arb_vec_t;

   arb_vec_t vecs [8];
   int       base, ebase;

   initial begin
      vecs[0] = '{-1, 4'b0001, 4'b0001};
      vecs[1] = '{-1, 4'b1010, 4'b0010};
      vecs[2] = '{-1, 4'b1111, 4'b0001};
      vecs[3] = '{ 1, 4'b1111, 4'b0100};
      vecs[4] = '{ 3, 4'b1010, 4'b0010};
      vecs[5] = '{ 2, 4'b0011, 4'b0001};
      vecs[6] = '{ 2, 4'b1001, 4'b1000};
      vecs[7] = '{ 0, 4'b0001, 4'b0001};

      rst_n = 1'b0;
      do_reset();
      check("rst_grant",  32'(grant),   32'd0);
      check("rst_busy",   32'(busy),    32'd0);
      check("rst_tx_req", 32'(tx_req),  32'd0);
      check("rst_tx_din", 32'(tx_din),  32'd0);
      check("rst_err",    32'(err),     32'd0);
      check("rst_req_rdy", 32'(req_rdy), 32'd0);

      // Single two-byte packet from requester 0.
      base = log_n;
      push(0, 8'h41, 1'b0);
      push(0, 8'h54, 1'b1);
      en = 4'b0001;
      wait_idle("single", 500);
      check("single_count", 32'(log_n - base), 32'd2);
      check_entry("single_b0", base, 0, 8'h41);
      check_entry("single_b1", base + 1, 0, 8'h54);
      check("single_grant_lat", 32'(gnt_set_cyc - vld_rise_cyc), 32'd1);
      check("single_txreq_lat", 32'(log_cyc[base] - gnt_set_cyc), 32'd1);
      check("single_release_lat", 32'(gnt_clr_cyc - rise_cyc), 32'd1);
      check("single_grant_end", 32'(grant), 32'd0);
      check("single_din_held", 32'(tx_din), 32'h54);
      // ptr is now 1, so requester 1 beats requester 0.
      push(0, 8'h11, 1'b1);
      push(1, 8'h22, 1'b1);
      en = 4'b0011;
      repeat (2) tick();
      check("single_ptr", 32'(grant), 32'b0010);
      wait_idle("single_ptr", 500);

      // Table: arbitration from a known pointer.
      for (int v = 0; v < 8; v++) begin
         int k;
         do_reset();
         if (vecs[v].warm >= 0) begin
            push(vecs[v].warm, 8'h5A, 1'b1);
            en = N'(1) << vecs[v].warm;
            wait_idle($sformatf("arb%0d_warm", v), 300);
            en = '0;
         end
         for (int i = 0; i < N; i++) if (vecs[v].vld[i]) push(i, 8'(8'h60 + v), 1'b1);
         en = vecs[v].vld;
         k = 0;
         while (grant == '0 && k < 20) begin tick(); k++; end
         check($sformatf("arb%0d_grant", v), 32'(grant), 32'(vecs[v].exp));
         check($sformatf("arb%0d_rdy", v), 32'(req_rdy), 32'(vecs[v].exp));
         wait_idle($sformatf("arb%0d", v), 1000);
         en = '0;
      end

      // Contention: four two-byte packets, served 0..3 without interleaving.
      do_reset();
      base = log_n;
      for (int i = 0; i < N; i++) begin
         push(i, 8'(8'h11 + 16 * i), 1'b0);
         push(i, 8'(8'h12 + 16 * i), 1'b1);
      end
      en = 4'b1111;
      wait_idle("cont", 2000);
      check("cont_count", 32'(log_n - base), 32'd8);
      for (int k = 0; k < 8; k++)
         check_entry($sformatf("cont_b%0d", k), base + k, k / 2, 8'(8'h11 + 16 * (k / 2) + (k % 2)));

      // Fairness: requester 1 re-requests at once while 3 waits.
      do_reset();
      base = log_n;
      push(1, 8'hA1, 1'b1);
      push(1, 8'hA2, 1'b1);
      push(3, 8'hB1, 1'b1);
      en = 4'b1010;
      wait_idle("fair", 1000);
      check("fair_count", 32'(log_n - base), 32'd3);
      check_entry("fair_p0", base, 1, 8'hA1);
      check_entry("fair_p1", base + 1, 3, 8'hB1);
      check_entry("fair_p2", base + 2, 1, 8'hA2);

      // Hold timeout: requester 0 stalls after byte 1 of 3; requester 2 waits.
      do_reset();
      base  = log_n;
      ebase = err_cnt;
      push(0, 8'h01, 1'b0);
      en = 4'b0001;
      wait_log("hold", base + 1, 100);
      push(2, 8'hC1, 1'b1);
      en = 4'b0101;
      repeat (FRAME + 4) tick();
      check("hold_masked_rdy", 32'(req_rdy), 32'd0);
      check("hold_grant_mid", 32'(grant), 32'b0001);
      wait_err("hold", ebase, HOLD_TO + 100);
      check("hold_err_time", 32'(err_cyc - rise_cyc), 32'(HOLD_TO + 1));
      check("hold_grant_rel", 32'(grant), 32'd0);
      check("hold_busy_rel", 32'(busy), 32'd0);
      tick();
      check("hold_err_pulse", 32'(err), 32'd0);
      wait_idle("hold", 500);
      check("hold_count", 32'(log_n - base), 32'd2);
      check_entry("hold_next", base + 1, 2, 8'hC1);
      check("hold_err_cnt", 32'(err_cnt - ebase), 32'd1);

      // Start timeout: serializer never leaves idle.
      do_reset();
      stuck = 1'b1;
      base  = log_n;
      ebase = err_cnt;
      push(3, 8'hD1, 1'b1);
      en = 4'b1000;
      wait_err("start", ebase, 200);
      check("start_err_time", 32'(err_cyc - log_cyc[base]), 32'(START_TO));
      check("start_busy", 32'(busy), 32'd0);
      check("start_grant", 32'(grant), 32'd0);
      check("start_din", 32'(tx_din), 32'hD1);
      stuck = 1'b0;

      // Reset in the middle of a frame, then a normal packet.
      do_reset();
      base = log_n;
      push(0, 8'h33, 1'b0);
      push(0, 8'h34, 1'b1);
      en = 4'b0001;
      wait_log("mid", base + 1, 100);
      repeat (5) tick();
      check("mid_in_frame", 32'(tx_idle), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_tx_req", 32'(tx_req), 32'd0);
      check("mid_grant",  32'(grant),  32'd0);
      check("mid_busy",   32'(busy),   32'd0);
      check("mid_tx_din", 32'(tx_din), 32'd0);
      check("mid_err",    32'(err),    32'd0);
      en = '0;
      flush_cnt++;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      base = log_n;
      push(1, 8'hE1, 1'b1);
      en = 4'b0010;
      wait_idle("mid_after", 500);
      check("mid_after_count", 32'(log_n - base), 32'd1);
      check_entry("mid_after_b0", base, 1, 8'hE1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
